regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register bank: successor of the single-write, two-read registerbank.
//  Configurable width, depth, read-port count and write-port count.
//  Adds optional hard-wired zero register, same-cycle write->read bypass, and a sequential bulk-clear sweep.
//  Serves as the datapath register file between decode (reads) and writeback (writes).
// PARAMETERS
//  DW        32  data width in bits
//  NREG      32  number of registers (>=2)
//  AW        $clog2(NREG)  address width (derived localparam; not overridable)
//  NRD       2   read ports (>=1)
//  NWR       2   write ports (>=1)
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes
//  BYPASS    1   1: a read of an address written this cycle returns the new data
// PORTS
//  clk       in   1        rising-edge clock
//  reset_n   in   1        asynchronous, active-low reset
//  wr_en     in   NWR      per-port write enable; bit k belongs to port k
//  wr_addr   in   NWR*AW   port k occupies [k*AW +: AW]
//  wr_data   in   NWR*DW   port k occupies [k*DW +: DW]
//  rd_addr   in   NRD*AW   port j occupies [j*AW +: AW]
//  rd_data   out  NRD*DW   port j occupies [j*DW +: DW]; combinational
//  clr_req   in   1        start a bulk-clear sweep (sampled at posedge)
//  clr_busy  out  1        sweep in progress; writes are ignored while high
// BEHAVIOUR
//  Reset: reset_n low clears all registers to 0, FSM to IDLE and sweep index to 0, with no clock needed.
//   While reset is held: clr_busy=0 and rd_data=0.
//  Writes: commit on posedge when wr_en[k]=1, clr_busy=0 and the address is < NREG.
//   Out-of-range addresses are dropped.
//  Write conflict: when several enabled ports target the same address, the highest-index port wins.
//  ZERO_REG=1: writes to address 0 are dropped; rd_data for address 0 is always 0.
//  Reads: zero-latency combinational.
//   Out-of-range address reads 0.
//   BYPASS=1 and clr_busy=0: if an enabled write port targets the read address this cycle,
//    rd_data = that write data, using the same priority rule. Never bypasses to address 0 when ZERO_REG=1.
//   BYPASS=0: rd_data shows the pre-edge contents.
//  FSM: IDLE, SWEEP.
//   IDLE: clr_req=1 at posedge -> SWEEP, idx=0, clr_busy=1 from that edge onward.
//    Writes in that same cycle still commit, because clr_busy was 0 when sampled.
//   SWEEP: each posedge clears reg[idx] and increments idx.
//    When idx==NREG-1 is cleared -> IDLE, clr_busy=0.
//    clr_busy is therefore high for exactly NREG cycles.
//    clr_req during SWEEP is ignored; it does not restart or extend the sweep.
//    Reads during SWEEP return current contents (already-swept registers read 0); no bypass.
//  Reset mid-sweep: everything is cleared immediately; FSM returns to IDLE.
//  Sweep index width is AW, and the index never wraps past NREG-1.
// STRUCTURE
//  Shared package regfile_pkg: FSM state encoding (IDLE=1'b0, SWEEP=1'b1), DW/NREG defaults,
//   and a function clog2 used for AW.
//  One sub-module: regfile_wr_arb.
//   Per address: resolves the winning write port (highest index) and produces hit + data.
//   Shared by the storage update and the bypass path.
//  Storage array, FSM and read muxes sit in regfile_mp.
// TESTING
//  T1 reset: reset_n low with no clock running -> every rd_data=0 and clr_busy=0.
//  T2 basic write: wr_en[0]=1, addr 3, data 666 for one edge; rd_addr0 moves 6->3.
//   Before the edge: rd_data0=666 (bypass); after the edge: 666 with wr_en=0; rd_data for addr 6 stays 0.
//  T3 conflict: port0 writes 5<-111 and port1 writes 5<-222 on the same edge -> reg5=222.
//   Repeat with BYPASS=0 and check that pre-edge rd_data=0.
//  T4 zero register: write 0<-0xDEADBEEF -> rd_data for addr 0 reads 0.
//   With ZERO_REG=0 the same write reads back 0xDEADBEEF.
//  T5 sweep: fill regs 1..31 with a counter value, pulse clr_req.
//   clr_busy high exactly 32 cycles; reg k reads 0 from cycle k+1.
//   A write during the sweep is dropped, and a second clr_req mid-sweep does not extend it.
//  T6 reset mid-sweep: drop reset_n at sweep cycle 10 -> clr_busy=0 and all registers 0 at once.
//   A fresh write afterwards succeeds.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding,
// default geometry and the address-width helper.
package regfile_pkg;

    localparam int DEFAULT_DW   = 32;
    localparam int DEFAULT_NREG = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Smallest r such that 2**r >= n; evaluated at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write arbiter for one register address: reports whether any enabled
// write port targets this address and, if several do, the data of the
// highest-index port.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DW  = DEFAULT_DW,
    parameter int AW  = 5,
    parameter int NWR = 2
) (
    input  logic [NWR-1:0]    i_wrEn,
    input  logic [NWR*AW-1:0] i_wrAddr,
    input  logic [NWR*DW-1:0] i_wrData,
    input  logic [AW-1:0]     i_addr,
    output logic              o_hit,
    output logic [DW-1:0]     o_data
);

    // Scan ports in ascending order so the last match (highest index) wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < NWR; k++) begin
            if (i_wrEn[k] && (i_wrAddr[k*AW +: AW] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_wrData[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional hard-wired zero
// register, same-cycle write->read bypass and a sequential bulk-clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int NREG     = DEFAULT_NREG,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NWR-1:0]                 wr_en,
    input  logic [NWR*clog2(NREG)-1:0]     wr_addr,
    input  logic [NWR*DW-1:0]              wr_data,
    input  logic [NRD*clog2(NREG)-1:0]     rd_addr,
    output logic [NRD*DW-1:0]              rd_data,
    input  logic                           clr_req,
    output logic                           clr_busy
);

    localparam int AW = clog2(NREG);

    logic [DW-1:0] r_regs [NREG];
    logic [NREG-1:0] w_hit;
    logic [DW-1:0] w_hitData [NREG];

    state_t r_state;
    state_t w_nextState;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_nextIdx;

    // One arbiter per register; its result feeds both storage and bypass.
    // Out-of-range write addresses match no arbiter and are dropped.
    for (genvar a = 0; a < NREG; a++) begin : g_arb
        regfile_wr_arb #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_arb (
            .i_wrEn   (wr_en),
            .i_wrAddr (wr_addr),
            .i_wrData (wr_data),
            .i_addr   (AW'(a)),
            .o_hit    (w_hit[a]),
            .o_data   (w_hitData[a])
        );
    end

    assign clr_busy = (r_state == SWEEP);

    // Sweep FSM state and index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
        end
    end

    // Next-state logic: a sweep visits every register once and never wraps.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_nextState = SWEEP;
                    w_nextIdx   = '0;
                end
            end
            SWEEP: begin
                if (r_idx == AW'(NREG - 1)) begin
                    w_nextState = IDLE;
                    w_nextIdx   = '0;
                end else begin
                    w_nextIdx = r_idx + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextIdx   = '0;
            end
        endcase
    end

    // Storage: sweep clears one register per edge, otherwise arbitrated writes commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < NREG; a++) begin
                r_regs[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NREG; a++) begin
                if (clr_busy) begin
                    if (r_idx == AW'(a)) begin
                        r_regs[a] <= '0;
                    end
                end else if (w_hit[a] && !(ZERO_REG && (a == 0))) begin
                    r_regs[a] <= w_hitData[a];
                end
            end
        end
    end

    // Read muxes: unmatched addresses and the zero register read 0; bypass only outside a sweep.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int a = 0; a < NREG; a++) begin
                if (reset_n && (rd_addr[j*AW +: AW] == AW'(a)) && !(ZERO_REG && (a == 0))) begin
                    if (BYPASS && !clr_busy && w_hit[a]) begin
                        rd_data[j*DW +: DW] = w_hitData[a];
                    end else begin
                        rd_data[j*DW +: DW] = r_regs[a];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Three instances share one stimulus:
// cfg0 = defaults, cfg1 = BYPASS off, cfg2 = ZERO_REG off.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    logic clkRun = 1'b0;
    logic resetN;
    logic [NWR-1:0] wrEn;
    logic [NWR*AW-1:0] wrAddr;
    logic [NWR*DW-1:0] wrData;
    logic [NRD*AW-1:0] rdAddr;
    logic clrReq;
    logic [NRD*DW-1:0] rdData [NCFG];
    logic busy [NCFG];

    logic [DW-1:0] memZ [NREG];
    logic [DW-1:0] memN [NREG];
    int sweepLeft;
    int assertCount = 0;
    int failCount = 0;

    regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(resetN), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdData[0]), .clr_req(clrReq), .clr_busy(busy[0]));

    regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dutNb (
        .clk(clk), .reset_n(resetN), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdData[1]), .clr_req(clrReq), .clr_busy(busy[1]));

    regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b0), .BYPASS(1'b1)) dutNz (
        .clk(clk), .reset_n(resetN), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdData[2]), .clr_req(clrReq), .clr_busy(busy[2]));

    // Gated clock so the reset test can run with no clock at all.
    always #5 if (clkRun) clk = ~clk;

    task automatic modelReset();
        for (int a = 0; a < NREG; a++) begin
            memZ[a] = '0;
            memN[a] = '0;
        end
        sweepLeft = 0;
    endtask

    // One clock edge of the reference: either clear the next swept register,
    // or apply writes in port order (later port overrides) and maybe start a sweep.
    task automatic modelEdge();
        if (sweepLeft > 0) begin
            memZ[NREG - sweepLeft] = '0;
            memN[NREG - sweepLeft] = '0;
            sweepLeft--;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                int a;
                a = int'(wrAddr[k*AW +: AW]);
                if (wrEn[k] && a < NREG) begin
                    if (a != 0) memZ[a] = wrData[k*DW +: DW];
                    memN[a] = wrData[k*DW +: DW];
                end
            end
            if (clrReq) sweepLeft = NREG;
        end
    endtask

    function automatic logic [DW-1:0] modelRead(input int cfg, input int addr);
        bit zr;
        bit byp;
        zr  = (cfg != 2);
        byp = (cfg != 1);
        if (resetN !== 1'b1 || addr >= NREG) return '0;
        if (zr && addr == 0) return '0;
        if (byp && sweepLeft == 0) begin
            for (int k = NWR - 1; k >= 0; k--) begin
                if (wrEn[k] && int'(wrAddr[k*AW +: AW]) == addr) return wrData[k*DW +: DW];
            end
        end
        return zr ? memZ[addr] : memN[addr];
    endfunction

    task automatic checkOutput(input string tag);
        logic [DW-1:0] obs;
        logic [DW-1:0] exp;
        logic expBusy;
        expBusy = (sweepLeft > 0);
        for (int c = 0; c < NCFG; c++) begin
            for (int j = 0; j < NRD; j++) begin
                obs = rdData[c][j*DW +: DW];
                exp = modelRead(c, int'(rdAddr[j*AW +: AW]));
                assertCount++;
                assert (obs === exp) else begin
                    failCount++;
                    $error("[TB] FAIL %s cfg%0d rd%0d addr=%0d observed=%h expected=%h",
                           tag, c, j, rdAddr[j*AW +: AW], obs, exp);
                end
            end
            assertCount++;
            assert (busy[c] === expBusy) else begin
                failCount++;
                $error("[TB] FAIL %s cfg%0d clr_busy observed=%b expected=%b", tag, c, busy[c], expBusy);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic [NWR-1:0] en, input logic [NWR*AW-1:0] wa,
                                 input logic [NWR*DW-1:0] wd, input logic [NRD*AW-1:0] ra,
                                 input logic clr);
        wrEn   = en;
        wrAddr = wa;
        wrData = wd;
        rdAddr = ra;
        clrReq = clr;
    endtask

    initial begin
        int busyCount;
        int guard;
        resetN = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0);
        modelReset();

        // T1: reset held, no clock, even with writes enabled everything reads 0
        #3;
        applyStimulus(2'b11, {5'd3, 5'd3}, {32'h1234, 32'h5678}, {5'd3, 5'd0}, 1'b0);
        #1 checkOutput("T1 reset");
        rdAddr = {5'd31, 5'd7};
        #1 checkOutput("T1 reset2");
        wrEn = '0;
        #1 resetN = 1'b1;
        #1 checkOutput("T1 released");
        clkRun = 1'b1;

        // T2: basic write with bypass before the edge
        applyStimulus(2'b01, {5'd0, 5'd3}, {32'd0, 32'd666}, {5'd6, 5'd3}, 1'b0);
        #1 checkOutput("T2 pre");
        cycle();
        wrEn = '0;
        #1 checkOutput("T2 post");

        // T3: same-address conflict, higher port wins
        applyStimulus(2'b11, {5'd5, 5'd5}, {32'd222, 32'd111}, {5'd3, 5'd5}, 1'b0);
        #1 checkOutput("T3 pre");
        cycle();
        wrEn = '0;
        #1 checkOutput("T3 post");

        // T4: zero register
        applyStimulus(2'b10, {5'd0, 5'd9}, {32'hDEADBEEF, 32'd0}, {5'd0, 5'd0}, 1'b0);
        #1 checkOutput("T4 pre");
        cycle();
        wrEn = '0;
        #1 checkOutput("T4 post");

        // Random traffic with narrow address ranges to provoke conflicts and bypass hits
        for (int i = 0; i < 300; i++) begin
            int span;
            span = (i % 2 == 0) ? 7 : 31;
            applyStimulus(2'($urandom_range(0, 3)),
                          {5'($urandom_range(0, span)), 5'($urandom_range(0, span))},
                          {32'($urandom), 32'($urandom)},
                          {5'($urandom_range(0, span)), 5'($urandom_range(0, span))},
                          1'($urandom_range(0, 63) == 0));
            #1 checkOutput("RAND");
            cycle();
        end

        // T5: let any random sweep finish, fill 1..31, then sweep
        applyStimulus('0, '0, '0, '0, 1'b0);
        guard = 0;
        while (busy[0] === 1'b1 && guard < 100) begin
            cycle();
            guard++;
        end
        assertCount++;
        assert (busy[0] === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL T5 idle-wait clr_busy observed=%b expected=0", busy[0]);
        end
        for (int k = 1; k < NREG; k++) begin
            applyStimulus(2'b01, {5'd0, 5'(k)}, {32'd0, 32'(k * 7 + 1)}, {5'(k - 1), 5'(k)}, 1'b0);
            #1 checkOutput("T5 fill");
            cycle();
        end
        applyStimulus('0, '0, '0, {5'd31, 5'd1}, 1'b1);
        #1 checkOutput("T5 start");
        cycle();
        busyCount = 0;
        guard = 0;
        while (busy[0] === 1'b1 && guard < 100) begin
            busyCount++;
            applyStimulus('0, '0, '0, {5'($urandom_range(0, 31)), 5'(guard % NREG)}, 1'b0);
            if (guard == 5) begin
                wrEn = 2'b01;
                wrAddr = {5'd0, 5'd20};
                wrData = {32'd0, 32'hFF};
            end
            if (guard == 10) clrReq = 1'b1;
            #1 checkOutput("T5 sweep");
            cycle();
            guard++;
        end
        clrReq = 1'b0;
        wrEn = '0;
        assertCount++;
        assert (busyCount === NREG) else begin
            failCount++;
            $error("[TB] FAIL T5 busy-length observed=%0d expected=%0d", busyCount, NREG);
        end
        for (int a = 0; a < NREG / 2; a++) begin
            rdAddr = {5'(a + 16), 5'(a)};
            #1 checkOutput("T5 after");
            cycle();
        end

        // T6: reset in the middle of a sweep
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b11, {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))},
                          {32'($urandom), 32'($urandom)}, {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))}, 1'b0);
            cycle();
        end
        applyStimulus('0, '0, '0, '0, 1'b1);
        cycle();
        clrReq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rdAddr = {5'(31 - i), 5'(i)};
            #1 checkOutput("T6 sweep");
            cycle();
        end
        #2 resetN = 1'b0;
        modelReset();
        #1 checkOutput("T6 in reset");
        #1 resetN = 1'b1;
        for (int a = 0; a < NREG / 2; a++) begin
            rdAddr = {5'(a + 16), 5'(a)};
            #1 checkOutput("T6 cleared");
            cycle();
        end
        applyStimulus(2'b01, {5'd0, 5'd12}, {32'd0, 32'hCAFE0012}, {5'd0, 5'd12}, 1'b0);
        #1 checkOutput("T6 write pre");
        cycle();
        wrEn = '0;
        #1 checkOutput("T6 write post");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
